// File: rtl/stream_accumulator_pkg.sv
// Shared types and arithmetic helpers for the stream accumulator.
// Holds the group state enum and the saturating add used when STREAM_ACCUMULATOR_SATURATE_EN is defined.
package stream_accumulator_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_PARTIAL
    } state_t;

    // Operands are zero-extended to 32 bits; w is the result width (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/stream_accumulator_out_reg.sv
// Output register for one group total with valid/ready hold behaviour.
// A new total may be loaded in the same cycle the previous one is taken.
module stream_accumulator_out_reg #(
    parameter int out_width = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [out_width-1:0] load_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [out_width-1:0] out_data
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_accumulator.sv
// Sums every n consecutive input elements and emits one total per group over valid/ready.
// Define STREAM_ACCUMULATOR_SATURATE_EN to clamp sums at 2^out_width-1 instead of wrapping.
module stream_accumulator
    import stream_accumulator_pkg::*;
#(
    parameter int width     = 4,
    parameter int n         = 4,
    parameter int out_width = width + $clog2(n)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] out_data
);

    localparam int              cnt_w    = $clog2(n);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n - 1);

    state_t                 state;
    logic [cnt_w-1:0]       cnt;
    logic [out_width-1:0]   acc;
    logic [out_width-1:0]   acc_base;
    logic [out_width-1:0]   sum;
    logic                   last;
    logic                   in_fire;

    assign last     = (cnt == last_cnt);
    // NOTE: in_ready is combinational; only the group-completing element waits for the output slot.
    assign in_ready = ~last | ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign acc_base = (state == ST_EMPTY) ? '0 : acc;

`ifdef STREAM_ACCUMULATOR_SATURATE_EN
    assign sum = out_width'(sat_add(32'(acc_base), 32'(in_data), out_width));
`else
    assign sum = acc_base + out_width'(in_data);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            cnt   <= '0;
            acc   <= '0;
        end else if (in_fire) begin
            if (last) begin
                state <= ST_EMPTY;
                cnt   <= '0;
                acc   <= '0;
            end else begin
                state <= ST_PARTIAL;
                cnt   <= cnt + cnt_w'(1);
                acc   <= sum;
            end
        end
    end

    stream_accumulator_out_reg #(
        .out_width (out_width)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (in_fire & last),
        .load_data (sum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
